store_queue: RTL

Write-side memory responder for the single-cycle RV64 core's store interface (`memwrite`, `address`, `data`). It accepts at most one doubleword store per cycle and checks each for alignment and address range. Legal stores are buffered in a DEPTH-entry FIFO and drained to the downstream memory bus with a valid/ready handshake. A flush handshake lets the core drain all pending stores before halting on ebreak.

---
 rtl/store_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/store_queue.sv
// Store-side responder for the RV64 core: classifies each store, buffers legal ones in a FIFO
// and drains them downstream over valid/ready; a flush FSM lets the core wait for an empty queue.
module store_queue #(
    parameter int          DEPTH = 4,
    parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000,
    parameter logic [63:0] SIZE  = 64'h0000_0000_0800_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       memwrite,
    input  logic [63:0]                address,
    input  logic [63:0]                data,
    output logic                       stall,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       mem_valid,
    output logic [63:0]                mem_addr,
    output logic [63:0]                mem_wdata,
    input  logic                       mem_ready,
    output logic                       err_misalign,
    output logic                       err_range,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                store_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [64:0]   LO_ADDR = {1'b0, BASE};
    localparam logic [64:0]   HI_ADDR = {1'b0, BASE} + {1'b0, SIZE};

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [PW-1:0] head, tail;
    logic [63:0]   addr_q [DEPTH];
    logic [63:0]   data_q [DEPTH];
    logic          accept, misalign, out_of_range, push, pop;

    // Everything the core and the bus see is decoded from registers only.
    assign stall      = (count == FULL) || (state != IDLE);
    assign mem_valid  = (count != '0);
    assign mem_addr   = addr_q[head];
    assign mem_wdata  = data_q[head];
    assign flush_done = (state == DONE);

    assign accept       = memwrite && !stall;
    assign misalign     = (address[2:0] != 3'b000);
    assign out_of_range = ({1'b0, address} < LO_ADDR) || ({1'b0, address} >= HI_ADDR);
    assign push         = accept && !misalign && !out_of_range;
    assign pop          = mem_valid && mem_ready;

    // Storage needs no reset: entries are only observed while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= address;
            data_q[tail] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            store_cnt    <= '0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            state        <= IDLE;
        end else begin
            state <= state_next;
            if (push) begin
                tail      <= tail + PW'(1);
                store_cnt <= store_cnt + 32'd1;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (accept && misalign) begin
                err_misalign <= 1'b1;
            end
            if (accept && out_of_range) begin
                err_range <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_req) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
endmodule
